// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcodes, FSM states,
// flag bit positions and iterative-unit modes.
package alu_seq_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;
    localparam logic [7:0] OP_NOT = 8'h07;
    localparam logic [7:0] OP_SHL = 8'h08;
    localparam logic [7:0] OP_SHR = 8'h09;
    localparam logic [7:0] OP_ASR = 8'h0A;
    localparam logic [7:0] OP_MUL = 8'h0B;
    localparam logic [7:0] OP_CMP = 8'h0C;
    localparam logic [7:0] OP_ADC = 8'h0D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_CARRY   = 2;
    localparam int FLAG_OVF     = 3;
    localparam int FLAG_ILLEGAL = 4;
    localparam int NUM_FLAGS    = 5;

    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_ASR = 2'd2,
        IT_MUL = 2'd3
    } iter_mode_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unit: one-bit-per-cycle shifter and shift-add multiplier.
// done/value/carry describe the step taken on the coming clock edge.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  iter_mode_t       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] count,
    output logic             done,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    iter_mode_t           mode_q;
    logic [2*WIDTH-1:0]   work_q;
    logic [2*WIDTH-1:0]   work_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH:0]       mul_sum;
    logic                 step_carry;

    // MUL keeps {partial high half, remaining multiplier bits} in work_q.
    always_comb begin
        work_d     = work_q;
        step_carry = 1'b0;
        mul_sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                   + (work_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        case (mode_q)
            IT_SHL: begin
                work_d     = {{WIDTH{1'b0}}, work_q[WIDTH-2:0], 1'b0};
                step_carry = work_q[WIDTH-1];
            end
            IT_SHR: begin
                work_d     = {{WIDTH{1'b0}}, 1'b0, work_q[WIDTH-1:1]};
                step_carry = work_q[0];
            end
            IT_ASR: begin
                work_d     = {{WIDTH{1'b0}}, work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_carry = work_q[0];
            end
            IT_MUL: begin
                work_d     = {mul_sum, work_q[WIDTH-1:1]};
                step_carry = |work_d[2*WIDTH-1:WIDTH];
            end
            default: begin
                work_d     = work_q;
                step_carry = 1'b0;
            end
        endcase
    end

    assign done  = (cnt_q == CNT_W'(1));
    assign value = work_d[WIDTH-1:0];
    assign carry = step_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= IT_SHL;
            work_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mode_q  <= mode;
            work_q  <= (mode == IT_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            mcand_q <= a;
            cnt_q   <= count;
        end else if (cnt_q != '0) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU with valid/ready handshake on both sides; shifts by k>0 and
// MUL run through the iterative unit, everything else completes in one cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OP_W    = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_illegal,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;

    logic                 accept;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic                 is_exec;

    logic [WIDTH-1:0]     sc_acc;
    logic [NUM_FLAGS-1:0] sc_flags;
    logic [WIDTH-1:0]     sc_val;
    logic [WIDTH:0]       sc_sum;
    logic                 sc_c, sc_v, sc_upd, sc_wr;

    logic                 iter_start;
    iter_mode_t           iter_mode;
    logic [CNT_W-1:0]     iter_count;
    logic                 iter_done;
    logic [WIDTH-1:0]     iter_value;
    logic                 iter_carry;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == EXEC);
    assign result    = acc_q;

    assign flag_zero    = flags_q[FLAG_ZERO];
    assign flag_neg     = flags_q[FLAG_NEG];
    assign flag_carry   = flags_q[FLAG_CARRY];
    assign flag_ovf     = flags_q[FLAG_OVF];
    assign flag_illegal = flags_q[FLAG_ILLEGAL];

    assign shamt    = operand[SHAMT_W-1:0];
    assign is_shift = (opcode == OP_W'(OP_SHL)) || (opcode == OP_W'(OP_SHR))
                   || (opcode == OP_W'(OP_ASR));
    assign is_exec  = (is_shift && (shamt != '0)) || (opcode == OP_W'(OP_MUL));

    always_comb begin
        iter_mode  = IT_MUL;
        iter_count = CNT_W'(WIDTH);
        if (opcode == OP_W'(OP_SHL)) begin
            iter_mode  = IT_SHL;
            iter_count = CNT_W'(shamt);
        end else if (opcode == OP_W'(OP_SHR)) begin
            iter_mode  = IT_SHR;
            iter_count = CNT_W'(shamt);
        end else if (opcode == OP_W'(OP_ASR)) begin
            iter_mode  = IT_ASR;
            iter_count = CNT_W'(shamt);
        end
    end

    // Single-cycle datapath; a zero-distance shift lands here and leaves acc alone.
    always_comb begin
        sc_val   = acc_q;
        sc_sum   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_upd   = 1'b1;
        sc_wr    = 1'b1;
        sc_flags = flags_q;
        sc_acc   = acc_q;
        case (opcode)
            OP_W'(OP_NOP): sc_upd = 1'b0;
            OP_W'(OP_LDA): sc_val = operand;
            OP_W'(OP_ADD), OP_W'(OP_ADC): begin
                sc_sum = {1'b0, acc_q} + {1'b0, operand}
                       + {{WIDTH{1'b0}}, (opcode == OP_W'(OP_ADC)) && flags_q[FLAG_CARRY]};
                sc_val = sc_sum[WIDTH-1:0];
                sc_c   = sc_sum[WIDTH];
                sc_v   = (acc_q[WIDTH-1] == operand[WIDTH-1])
                      && (sc_val[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_W'(OP_SUB), OP_W'(OP_CMP): begin
                sc_val = acc_q - operand;
                sc_c   = (acc_q < operand);
                sc_v   = (acc_q[WIDTH-1] != operand[WIDTH-1])
                      && (sc_val[WIDTH-1] != acc_q[WIDTH-1]);
                sc_wr  = (opcode == OP_W'(OP_SUB));
            end
            OP_W'(OP_AND): sc_val = acc_q & operand;
            OP_W'(OP_OR):  sc_val = acc_q | operand;
            OP_W'(OP_XOR): sc_val = acc_q ^ operand;
            OP_W'(OP_NOT): sc_val = ~acc_q;
            OP_W'(OP_SHL), OP_W'(OP_SHR), OP_W'(OP_ASR), OP_W'(OP_MUL): sc_val = acc_q;
            default: begin
                sc_upd                 = 1'b0;
                sc_flags[FLAG_ILLEGAL] = 1'b1;
            end
        endcase
        if (sc_upd) begin
            sc_flags[FLAG_ZERO]  = (sc_val == '0);
            sc_flags[FLAG_NEG]   = sc_val[WIDTH-1];
            sc_flags[FLAG_CARRY] = sc_c;
            sc_flags[FLAG_OVF]   = sc_v;
            if (sc_wr) begin
                sc_acc = sc_val;
            end
        end
        if (opcode == OP_W'(OP_NOP)) begin
            sc_flags[FLAG_ILLEGAL] = 1'b0;
        end else if (sc_upd) begin
            sc_flags[FLAG_ILLEGAL] = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
        case (state_q)
            IDLE: state_d = IDLE;
            EXEC: begin
                if (iter_done) begin
                    acc_d                 = iter_value;
                    flags_d[FLAG_ZERO]    = (iter_value == '0);
                    flags_d[FLAG_NEG]     = iter_value[WIDTH-1];
                    flags_d[FLAG_CARRY]   = iter_carry;
                    flags_d[FLAG_OVF]     = 1'b0;
                    flags_d[FLAG_ILLEGAL] = 1'b0;
                    state_d               = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // accept can only be high in IDLE or in DONE while the result is consumed.
        if (accept) begin
            if (is_exec) begin
                iter_start = 1'b1;
                state_d    = EXEC;
            end else begin
                acc_d   = sc_acc;
                flags_d = sc_flags;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (iter_start),
        .mode  (iter_mode),
        .a     (acc_q),
        .b     (operand),
        .count (iter_count),
        .done  (iter_done),
        .value (iter_value),
        .carry (iter_carry)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: handshake, latency, flags and reset behaviour
// against hand-computed expectations.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero, flag_neg, flag_carry, flag_ovf, flag_illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16), .OP_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .operand      (operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_zero    (flag_zero),
        .flag_neg     (flag_neg),
        .flag_carry   (flag_carry),
        .flag_ovf     (flag_ovf),
        .flag_illegal (flag_illegal),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle and out_ready low; returns at the
    // negedge where out_valid is first seen (or after a 100-cycle bound).
    task automatic do_op(input logic [7:0] op, input logic [15:0] opd,
                         output int lat, output int bcnt);
        chk1("in_ready_idle", in_ready, 1'b1);
        opcode   = op;
        operand  = opd;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = OP_NOP;
        operand  = 16'hFFFF;
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        $display("op=%h opd=%h -> result=%h z=%b n=%b c=%b v=%b ill=%b lat=%0d busy=%0d",
                 op, opd, result, flag_zero, flag_neg, flag_carry, flag_ovf,
                 flag_illegal, lat, bcnt);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int lat, bcnt, seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        opcode    = OP_NOP;
        operand   = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk1 ("rst_in_ready",  in_ready,  1'b1);
        chk1 ("rst_out_valid", out_valid, 1'b0);
        chk16("rst_result",    result,    16'h0000);
        chk1 ("rst_zero",      flag_zero, 1'b0);
        chk1 ("rst_neg",       flag_neg,  1'b0);
        chk1 ("rst_carry",     flag_carry, 1'b0);
        chk1 ("rst_ovf",       flag_ovf,  1'b0);
        chk1 ("rst_illegal",   flag_illegal, 1'b0);
        chk1 ("rst_busy",      busy,      1'b0);

        // Back-to-back LDA then ADD with out_ready held high
        out_ready = 1'b1;
        opcode    = OP_LDA;
        operand   = 16'h0012;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1 ("b2b_lda_valid", out_valid, 1'b1);
        chk16("b2b_lda_result", result, 16'h0012);
        chk1 ("b2b_in_ready", in_ready, 1'b1);
        $display("op=01 opd=0012 -> result=%h (back-to-back)", result);
        opcode  = OP_ADD;
        operand = 16'hFFEE;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk1 ("b2b_add_valid", out_valid, 1'b1);
        chk16("b2b_add_result", result, 16'h0000);
        chk1 ("b2b_add_zero",  flag_zero, 1'b1);
        chk1 ("b2b_add_carry", flag_carry, 1'b1);
        chk1 ("b2b_add_ovf",   flag_ovf, 1'b0);
        chk1 ("b2b_add_neg",   flag_neg, 1'b0);
        $display("op=02 opd=FFEE -> result=%h z=%b c=%b (back-to-back)", result, flag_zero, flag_carry);
        @(negedge clk);
        out_ready = 1'b0;
        chk1("b2b_back_idle", out_valid, 1'b0);

        // Signed overflow then compare
        do_op(OP_LDA, 16'h7FFF, lat, bcnt); consume();
        do_op(OP_ADD, 16'h0001, lat, bcnt);
        chki ("add_ovf_lat",    lat, 1);
        chk16("add_ovf_result", result, 16'h8000);
        chk1 ("add_ovf_neg",    flag_neg, 1'b1);
        chk1 ("add_ovf_ovf",    flag_ovf, 1'b1);
        chk1 ("add_ovf_carry",  flag_carry, 1'b0);
        consume();
        do_op(OP_CMP, 16'h8001, lat, bcnt);
        chk16("cmp_result", result, 16'h8000);
        chk1 ("cmp_carry",  flag_carry, 1'b1);
        chk1 ("cmp_zero",   flag_zero, 1'b0);
        chk1 ("cmp_neg",    flag_neg, 1'b1);
        consume();

        // Multi-cycle shift and zero-distance shift
        do_op(OP_LDA, 16'h1081, lat, bcnt); consume();
        do_op(OP_SHL, 16'h0004, lat, bcnt);
        chki ("shl_lat",    lat, 5);
        chki ("shl_busy",   bcnt, 4);
        chk16("shl_result", result, 16'h0810);
        chk1 ("shl_carry",  flag_carry, 1'b1);
        consume();
        do_op(OP_SHR, 16'h0000, lat, bcnt);
        chki ("shr0_lat",    lat, 1);
        chk16("shr0_result", result, 16'h0810);
        chk1 ("shr0_carry",  flag_carry, 1'b0);
        consume();

        // Multiply, back-pressure, then reset mid-EXEC
        do_op(OP_LDA, 16'h0123, lat, bcnt); consume();
        do_op(OP_MUL, 16'h0100, lat, bcnt);
        chki ("mul_lat",    lat, 17);
        chk16("mul_result", result, 16'h2300);
        chk1 ("mul_carry",  flag_carry, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk16("hold_result",   result, 16'h2300);
            chk1 ("hold_in_ready", in_ready, 1'b0);
            chk1 ("hold_valid",    out_valid, 1'b1);
        end
        consume();
        opcode   = OP_MUL;
        operand  = 16'h0003;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk1("mid_exec_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk16("mid_rst_result", result, 16'h0000);
        chk1 ("mid_rst_busy",   busy, 1'b0);
        chk1 ("mid_rst_valid",  out_valid, 1'b0);
        chk1 ("mid_rst_ready",  in_ready, 1'b1);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chki ("mid_rst_no_valid", seen, 0);
        chk16("mid_rst_acc_kept", result, 16'h0000);
        $display("reset during MUL EXEC -> result=%h out_valid seen %0d times", result, seen);

        // Illegal opcode then a legal op clears the flag
        do_op(OP_LDA, 16'h00AA, lat, bcnt); consume();
        do_op(8'hFF, 16'h1234, lat, bcnt);
        chki ("ill_lat",     lat, 1);
        chk16("ill_result",  result, 16'h00AA);
        chk1 ("ill_flag",    flag_illegal, 1'b1);
        consume();
        do_op(OP_AND, 16'h000F, lat, bcnt);
        chk16("and_result",  result, 16'h000A);
        chk1 ("and_illegal", flag_illegal, 1'b0);

        // Reset while in DONE drops out_valid without a clock edge
        chk1("done_valid_before", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("done_rst_valid",  out_valid, 1'b0);
        chk16("done_rst_result", result, 16'h0000);
        #1;
        rst = 1'b0;
        $display("reset during DONE -> out_valid=%b result=%h", out_valid, result);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
